// File: rtl/fir_interp_pkg.sv
// Shared constants, types and coefficient tables for the 2x interpolating FIR.
// The 17-tap low-pass prototype is split into an even-tap and an odd-tap
// polyphase branch. Both branches are symmetric, so tap order and storage
// order agree either way round.
package fir_interp_pkg;

   localparam int COEFF_WIDTH = 8;
   localparam int NUM_TAPS    = 17;
   localparam int P0_TAPS     = 9;
   localparam int P1_TAPS     = 8;

   // Growth of the accumulator over the input sample width.
   localparam int ACC_GROWTH  = 12;

   typedef logic signed [COEFF_WIDTH-1:0] coeff_t;

   // Even taps of the prototype: h[0], h[2], ..., h[16]. Element 0 is rightmost.
   localparam coeff_t [P0_TAPS-1:0] P0_COEFFS = {
      coeff_t'(-1), coeff_t'(-2), coeff_t'(6),  coeff_t'(21), coeff_t'(29),
      coeff_t'(21), coeff_t'(6),  coeff_t'(-2), coeff_t'(-1)
   };

   // Odd taps of the prototype: h[1], h[3], ..., h[15]. Element 0 is rightmost.
   localparam coeff_t [P1_TAPS-1:0] P1_COEFFS = {
      coeff_t'(-2), coeff_t'(0),  coeff_t'(13), coeff_t'(27),
      coeff_t'(27), coeff_t'(13), coeff_t'(0),  coeff_t'(-2)
   };

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      EMIT0 = 2'd1,
      EMIT1 = 2'd2
   } state_t;

endpackage

// File: rtl/fir_interp2_mac.sv
// Combinational full-precision dot product of one polyphase branch against
// the delay line. Products are IN_WIDTH+COEFF_WIDTH wide and are summed into
// an IN_WIDTH+ACC_GROWTH accumulator, so nothing is rounded or saturated.
module fir_interp2_mac
   import fir_interp_pkg::*;
#(
   parameter int                  IN_WIDTH = 16,
   parameter int                  N_TAPS   = P0_TAPS,
   parameter coeff_t [N_TAPS-1:0] COEFFS   = '0
)(
   input  logic [N_TAPS*IN_WIDTH-1:0]             i_x_flat,
   output logic signed [IN_WIDTH+ACC_GROWTH-1:0]  o_acc
);

   localparam int PROD_WIDTH = IN_WIDTH + COEFF_WIDTH;
   localparam int ACC_WIDTH  = IN_WIDTH + ACC_GROWTH;

   logic signed [PROD_WIDTH-1:0] w_prod [N_TAPS];

   // One signed multiplier per tap; both operands are sign-extended to the
   // product width first so the multiply is exact at that width.
   for (genvar gi = 0; gi < N_TAPS; gi++) begin : g_tap
      logic signed [PROD_WIDTH-1:0] w_x_ext;
      logic signed [PROD_WIDTH-1:0] w_c_ext;
      assign w_x_ext    = PROD_WIDTH'($signed(i_x_flat[gi*IN_WIDTH +: IN_WIDTH]));
      assign w_c_ext    = PROD_WIDTH'($signed(COEFFS[gi]));
      assign w_prod[gi] = w_x_ext * w_c_ext;
   end

   // Adder chain over all tap products, each sign-extended to the accumulator.
   always_comb begin
      o_acc = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         o_acc = o_acc + ACC_WIDTH'(w_prod[k]);
      end
   end

endmodule

// File: rtl/fir_interp2.sv
// 2x interpolating low-pass FIR. Each accepted input shifts the delay line
// and produces two outputs: the even-tap branch (y0) then the odd-tap branch
// (y1). y0 is loaded straight into the output register; y1 is parked until
// y0 has been taken. A new input is only accepted when the output side is
// empty or y1 is leaving in the same cycle, which gives 1 output per cycle.
module fir_interp2
   import fir_interp_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
)(
   input  logic                 s00_axis_aclk,
   input  logic                 s00_axis_areset,
   input  logic                 s00_axis_tvalid,
   input  logic [IN_WIDTH-1:0]  s00_axis_tdata,
   input  logic                 s00_axis_tlast,
   output logic                 s00_axis_tready,
   output logic                 m00_axis_tvalid,
   output logic [OUT_WIDTH-1:0] m00_axis_tdata,
   output logic                 m00_axis_tlast,
   input  logic                 m00_axis_tready
);

   localparam int ACC_WIDTH = IN_WIDTH + ACC_GROWTH;

   state_t                       r_state;
   logic signed [IN_WIDTH-1:0]   r_x [P0_TAPS];
   logic signed [ACC_WIDTH-1:0]  r_y1;
   logic                         r_last;
   logic                         r_tvalid;
   logic [OUT_WIDTH-1:0]         r_tdata;
   logic                         r_tlast;

   logic                         w_accept;
   logic [P0_TAPS*IN_WIDTH-1:0]  w_shift_flat;
   logic signed [ACC_WIDTH-1:0]  w_y0;
   logic signed [ACC_WIDTH-1:0]  w_y1;

   // Input is taken whenever nothing is pending, or when y1 is being handed
   // off this cycle. Deliberately independent of s00_axis_tvalid.
   assign s00_axis_tready = !s00_axis_areset &&
                            ((r_state == EMPTY) ||
                             ((r_state == EMIT1) && m00_axis_tready));
   assign w_accept = s00_axis_tvalid && s00_axis_tready;

   assign m00_axis_tvalid = r_tvalid;
   assign m00_axis_tdata  = r_tdata;
   assign m00_axis_tlast  = r_tlast;

   // The MACs see the line as it will be after this shift, so both branch
   // results can be registered on the accepting edge.
   assign w_shift_flat[IN_WIDTH-1:0] = s00_axis_tdata;
   for (genvar gi = 1; gi < P0_TAPS; gi++) begin : g_shift_view
      assign w_shift_flat[gi*IN_WIDTH +: IN_WIDTH] = r_x[gi-1];
   end

   fir_interp2_mac #(
      .IN_WIDTH (IN_WIDTH),
      .N_TAPS   (P0_TAPS),
      .COEFFS   (P0_COEFFS)
   ) u_mac_p0 (
      .i_x_flat (w_shift_flat),
      .o_acc    (w_y0)
   );

   fir_interp2_mac #(
      .IN_WIDTH (IN_WIDTH),
      .N_TAPS   (P1_TAPS),
      .COEFFS   (P1_COEFFS)
   ) u_mac_p1 (
      .i_x_flat (w_shift_flat[P1_TAPS*IN_WIDTH-1:0]),
      .o_acc    (w_y1)
   );

   // Delay line: each tap loads its upstream neighbour on accept; cleared on
   // reset but kept across packet boundaries.
   for (genvar gi = 0; gi < P0_TAPS; gi++) begin : g_delay
      always_ff @(posedge s00_axis_aclk) begin
         if (s00_axis_areset) begin
            r_x[gi] <= '0;
         end else if (w_accept) begin
            r_x[gi] <= $signed(w_shift_flat[gi*IN_WIDTH +: IN_WIDTH]);
         end
      end
   end

   // Output FSM with registered tdata/tlast/tvalid; an accept always reloads
   // y0 regardless of which state it happens in.
   always_ff @(posedge s00_axis_aclk) begin
      if (s00_axis_areset) begin
         r_state  <= EMPTY;
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tlast  <= 1'b0;
         r_y1     <= '0;
         r_last   <= 1'b0;
      end else if (w_accept) begin
         r_y1     <= w_y1;
         r_last   <= s00_axis_tlast;
         r_tdata  <= OUT_WIDTH'(w_y0);
         r_tlast  <= 1'b0;
         r_tvalid <= 1'b1;
         r_state  <= EMIT0;
      end else begin
         case (r_state)
            EMIT0: begin
               if (m00_axis_tready) begin
                  r_tdata <= OUT_WIDTH'(r_y1);
                  r_tlast <= r_last;
                  r_state <= EMIT1;
               end
            end
            EMIT1: begin
               if (m00_axis_tready) begin
                  r_tvalid <= 1'b0;
                  r_tlast  <= 1'b0;
                  r_state  <= EMPTY;
               end
            end
            default: begin
               r_state <= EMPTY;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_interp2.sv
// Directed bench for fir_interp2: impulse, DC, full-scale negative input,
// output backpressure, random downstream ready, tlast and mid-burst reset.
module tb_fir_interp2;

   logic        clk      = 1'b0;
   logic        areset   = 1'b1;
   logic        s_tvalid = 1'b0;
   logic [15:0] s_tdata  = '0;
   logic        s_tlast  = 1'b0;
   logic        s_tready;
   logic        m_tvalid;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic        m_tready = 1'b1;

   int     checks   = 0;
   int     failures = 0;
   int     cyc      = 0;
   bit     rnd_en   = 1'b0;
   longint got_d[$];
   bit     got_l[$];
   int     acc_cyc[$];
   longint exp_q[$];

   // Prototype impulse response, hand-copied.
   int H[17] = '{-1, -2, -2, 0, 6, 13, 21, 27, 29, 27, 21, 13, 6, 0, -2, -2, -1};

   always #5 clk = ~clk;

   fir_interp2 #(
      .IN_WIDTH  (16),
      .OUT_WIDTH (32)
   ) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_areset (areset),
      .s00_axis_tvalid (s_tvalid),
      .s00_axis_tdata  (s_tdata),
      .s00_axis_tlast  (s_tlast),
      .s00_axis_tready (s_tready),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tready (m_tready)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Record every handshake one half-cycle ahead of the edge that completes it.
   always @(negedge clk) begin
      if (!areset) begin
         if (m_tvalid && m_tready) begin
            got_d.push_back($signed(m_tdata));
            got_l.push_back(m_tlast);
         end
         if (s_tvalid && s_tready) acc_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_en) m_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic clear_q();
      got_d.delete();
      got_l.delete();
      acc_cyc.delete();
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      bit done;
      done     = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = last;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (s_tready) done = 1'b1;
         tick();
      end
      if (!done) check("send_timeout", 0, 1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_outputs(input int n);
      for (int i = 0; i < 400 && got_d.size() < n; i++) tick();
      for (int i = 0; i < 4; i++) tick();
   endtask

   task automatic do_reset();
      areset   = 1'b1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_m_tdata",  m_tdata,  0);
      check("rst_m_tlast",  m_tlast,  0);
      check("rst_s_tready", s_tready, 0);
      tick();
      areset = 1'b0;
      clear_q();
   endtask

   task automatic check_seq(input string tag, input longint exp_d[$]);
      check({tag, "_count"}, got_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size(); i++) begin
         if (i < got_d.size()) check($sformatf("%s[%0d]", tag, i), got_d[i], exp_d[i]);
      end
   endtask

   task automatic send_impulse(input logic [15:0] amp);
      send(amp, 1'b0);
      for (int i = 0; i < 8; i++) send(16'd0, 1'b0);
   endtask

   initial begin
      // ---- impulse ----
      do_reset();
      m_tready = 1'b1;
      send_impulse(16'd1);
      wait_outputs(18);
      exp_q.delete();
      for (int i = 0; i < 17; i++) exp_q.push_back(H[i]);
      exp_q.push_back(0);
      check_seq("impulse", exp_q);
      for (int i = 0; i < got_l.size(); i++) check($sformatf("impulse_tlast[%0d]", i), got_l[i], 0);

      // ---- DC: steady state and one accept every two cycles ----
      do_reset();
      for (int i = 0; i < 20; i++) send(16'd100, 1'b0);
      wait_outputs(40);
      check("dc_count", got_d.size(), 40);
      for (int i = 16; i < 40 && i < got_d.size(); i++)
         check($sformatf("dc[%0d]", i), got_d[i], (i % 2 == 0) ? 7700 : 7600);
      check("dc_accepts", acc_cyc.size(), 20);
      for (int i = 1; i < acc_cyc.size(); i++)
         check($sformatf("dc_accept_gap[%0d]", i), acc_cyc[i] - acc_cyc[i-1], 2);

      // ---- extreme negative full scale ----
      do_reset();
      for (int i = 0; i < 12; i++) send(16'h8000, 1'b0);
      wait_outputs(24);
      check("ext_count", got_d.size(), 24);
      for (int i = 16; i < 24 && i < got_d.size(); i++)
         check($sformatf("ext[%0d]", i), got_d[i], (i % 2 == 0) ? -2523136 : -2490368);

      // ---- backpressure: five stalled cycles in EMIT0 ----
      do_reset();
      m_tready = 1'b0;
      send(16'd1, 1'b0);
      s_tvalid = 1'b1;
      s_tdata  = 16'd0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("stall_tvalid[%0d]", i), m_tvalid, 1);
         check($sformatf("stall_tdata[%0d]", i), $signed(m_tdata), -1);
         check($sformatf("stall_tlast[%0d]", i), m_tlast, 0);
         check($sformatf("stall_s_tready[%0d]", i), s_tready, 0);
         tick();
      end
      m_tready = 1'b1;
      for (int i = 0; i < 8; i++) send(16'd0, 1'b0);
      wait_outputs(18);
      exp_q.delete();
      for (int i = 0; i < 17; i++) exp_q.push_back(H[i]);
      exp_q.push_back(0);
      check_seq("stall", exp_q);

      // ---- random downstream ready, scaled impulse ----
      do_reset();
      rnd_en = 1'b1;
      send_impulse(16'd3);
      wait_outputs(18);
      rnd_en   = 1'b0;
      m_tready = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 17; i++) exp_q.push_back(3 * H[i]);
      exp_q.push_back(0);
      check_seq("rnd", exp_q);

      // ---- tlast on a 3-sample packet ----
      do_reset();
      send(16'd1, 1'b0);
      send(16'd0, 1'b0);
      send(16'd0, 1'b1);
      wait_outputs(6);
      exp_q.delete();
      for (int i = 0; i < 6; i++) exp_q.push_back(H[i]);
      check_seq("pkt", exp_q);
      for (int i = 0; i < 6 && i < got_l.size(); i++)
         check($sformatf("pkt_tlast[%0d]", i), got_l[i], (i == 5) ? 1 : 0);

      // ---- reset while y1 is presented ----
      do_reset();
      send(16'd7, 1'b0);
      tick();
      areset = 1'b1;
      @(negedge clk);
      check("mid_pre_tvalid", m_tvalid, 1);
      check("mid_rst_s_tready", s_tready, 0);
      tick();
      areset = 1'b0;
      @(negedge clk);
      check("mid_post_tvalid", m_tvalid, 0);
      check("mid_post_tdata", m_tdata, 0);
      tick();
      clear_q();
      send_impulse(16'd1);
      wait_outputs(18);
      exp_q.delete();
      for (int i = 0; i < 17; i++) exp_q.push_back(H[i]);
      exp_q.push_back(0);
      check_seq("post_rst", exp_q);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
